// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives a synchronous imem, buffers responses in a
// 2-entry {instr, pc} FIFO and presents the head to decode, with redirect support.
module fetch_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [DATA_W-1:0] q_imem,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus1
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc1;
    } entry_t;

    logic [ADDR_W-1:0] pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    entry_t            head_r;
    entry_t            tail_r;
    logic              head_v_r;
    logic              tail_v_r;

    logic              pop_s;
    logic              issue_s;
    logic [1:0]        occ_s;
    entry_t            wr_entry_s;
    entry_t            head_n_s;
    entry_t            tail_n_s;
    logic              head_v_n_s;
    logic              tail_v_n_s;

    // Pop/issue decisions and next FIFO contents; the head slot always drives decode.
    always_comb begin
        pop_s            = head_v_r & dec_ready & ~redirect_valid;
        occ_s            = {1'b0, head_v_r} + {1'b0, tail_v_r} + {1'b0, inflight_r};
        issue_s          = ~redirect_valid & ((occ_s - {1'b0, pop_s}) < 2'd2);
        wr_entry_s.instr = q_imem;
        wr_entry_s.pc    = inflight_pc_r;
        wr_entry_s.pc1   = inflight_pc_r + ADDR_W'(1);
        head_n_s         = head_r;
        tail_n_s         = tail_r;
        head_v_n_s       = head_v_r;
        tail_v_n_s       = tail_v_r;
        if (pop_s) begin
            head_n_s   = tail_r;
            head_v_n_s = tail_v_r;
            tail_v_n_s = 1'b0;
        end else begin
            head_v_n_s = head_v_r;
        end
        // Issue throttling guarantees a free slot whenever a response lands.
        if (inflight_r) begin
            if (!head_v_n_s) begin
                head_n_s   = wr_entry_s;
                head_v_n_s = 1'b1;
            end else begin
                tail_n_s   = wr_entry_s;
                tail_v_n_s = 1'b1;
            end
        end else begin
            tail_n_s = tail_n_s;
        end
    end

    // Fetch PC, in-flight tracking and FIFO storage; redirect overrides everything else.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r          <= '0;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            head_r        <= '0;
            tail_r        <= '0;
            head_v_r      <= 1'b0;
            tail_v_r      <= 1'b0;
        end else if (redirect_valid) begin
            pc_r       <= redirect_pc;
            inflight_r <= 1'b0;
            head_v_r   <= 1'b0;
            tail_v_r   <= 1'b0;
        end else begin
            pc_r       <= issue_s ? pc_r + ADDR_W'(1) : pc_r;
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end
            head_r   <= head_n_s;
            tail_r   <= tail_n_s;
            head_v_r <= head_v_n_s;
            tail_v_r <= tail_v_n_s;
        end
    end

    assign address_imem = pc_r;
    assign if_valid     = head_v_r;
    assign if_instr     = head_r.instr;
    assign if_pc        = head_r.pc;
    assign if_pc_plus1  = head_r.pc1;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table, hand-written redirect/reset
// sequences, and an in-order scoreboard of every instruction decode accepts.
module tb_fetch_unit;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] address_imem;
    logic [DW-1:0] q_imem = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          dec_ready = 1'b0;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pc_plus1;

    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] sb_e;

    typedef struct {
        logic          rdy;
        logic          rv;
        logic [AW-1:0] rpc;
        logic          ev;
        logic [AW-1:0] epc;
        logic [AW-1:0] eaddr;
    } vec_t;
    vec_t tbl[22];

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clk), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1)
    );

    always #5 clk = ~clk;

    // Synchronous imem: data for the address sampled at an edge is visible the next cycle.
    always @(posedge clk) q_imem <= 32'hA000_0000 | {20'h0, address_imem};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_head(input string tag, input logic [AW-1:0] epc);
        logic [AW-1:0] p1;
        p1 = epc + 12'd1;
        chk({tag, "_valid"}, {31'h0, if_valid}, 32'h1);
        chk({tag, "_pc"}, {20'h0, if_pc}, {20'h0, epc});
        chk({tag, "_instr"}, if_instr, 32'hA000_0000 | {20'h0, epc});
        chk({tag, "_pc1"}, {20'h0, if_pc_plus1}, {20'h0, p1});
    endtask

    task automatic sb_restart(input logic [AW-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + AW'(i));
    endtask

    // Scoreboard: every accepted instruction must be the next one of the expected stream.
    always begin
        @(negedge clk);
        #2;
        if (reset && if_valid && dec_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow pc=%h required=none", if_pc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc", {20'h0, if_pc}, {20'h0, sb_e});
                chk("sb_instr", if_instr, 32'hA000_0000 | {20'h0, sb_e});
            end
        end
    end

    initial begin
        // rdy rv rpc | exp valid, exp if_pc, exp address_imem (observed before the edge)
        tbl[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000};
        tbl[1]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h001};
        tbl[2]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 12'h002};
        tbl[3]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 12'h003};
        tbl[4]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 12'h004};
        tbl[5]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h003, 12'h005};
        tbl[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 12'h006};
        tbl[7]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 12'h006};
        tbl[8]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 12'h006};
        tbl[9]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 12'h006};
        tbl[10] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 12'h006};
        tbl[11] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h004, 12'h006};
        tbl[12] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 12'h007};
        tbl[13] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h006, 12'h008};
        tbl[14] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h007, 12'h009};
        tbl[15] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h008, 12'h00A};
        tbl[16] = '{1'b0, 1'b1, 12'h100, 1'b1, 12'h008, 12'h00A};
        tbl[17] = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h100};
        tbl[18] = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h101};
        tbl[19] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h100, 12'h102};
        tbl[20] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h101, 12'h103};
        tbl[21] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h102, 12'h104};

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_addr", {20'h0, address_imem}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", {20'h0, if_pc}, 32'h0);
        chk("rst_pc1", {20'h0, if_pc_plus1}, 32'h0);
        reset = 1'b1;
        sb_restart(12'h000);

        for (int i = 0; i < 22; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("t%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].ev});
            chk($sformatf("t%0d_addr", i), {20'h0, address_imem}, {20'h0, tbl[i].eaddr});
            if (tbl[i].ev) chk_head($sformatf("t%0d", i), tbl[i].epc);
            dec_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            if (tbl[i].rv) sb_restart(tbl[i].rpc);
        end

        // Redirect near the top of the address space: the PC must wrap to zero.
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 12'hFFE; dec_ready = 1'b1;
        sb_restart(12'hFFE);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("wrap_bubble1", {31'h0, if_valid}, 32'h0);
        @(negedge clk);
        chk("wrap_bubble2", {31'h0, if_valid}, 32'h0);
        @(negedge clk); chk_head("wrap_ffe", 12'hFFE);
        @(negedge clk); chk_head("wrap_fff", 12'hFFF);
        chk("wrap_pc1_zero", {20'h0, if_pc_plus1}, 32'h0);
        @(negedge clk); chk_head("wrap_000", 12'h000);
        @(negedge clk); chk_head("wrap_001", 12'h001);

        // Redirect with decode ready while a response is landing: head not consumed, response dropped.
        @(negedge clk);
        chk("race_head_present", {31'h0, if_valid}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 12'h200;
        sb_restart(12'h200);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("race_bubble1", {31'h0, if_valid}, 32'h0);
        @(negedge clk);
        chk("race_bubble2", {31'h0, if_valid}, 32'h0);
        @(negedge clk); chk_head("race_200", 12'h200);
        @(negedge clk); chk_head("race_201", 12'h201);

        // Asynchronous reset between edges, then restart from address 0.
        repeat (3) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_addr", {20'h0, address_imem}, 32'h0);
        chk("arst_pc", {20'h0, if_pc}, 32'h0);
        chk("arst_instr", if_instr, 32'h0);
        repeat (2) @(negedge clk);
        chk("arst_hold_valid", {31'h0, if_valid}, 32'h0);
        reset = 1'b1;
        sb_restart(12'h000);
        chk("rel_c0_addr", {20'h0, address_imem}, 32'h0);
        @(negedge clk);
        chk("rel_c1_valid", {31'h0, if_valid}, 32'h0);
        chk("rel_c1_addr", {20'h0, address_imem}, 32'h1);
        @(negedge clk); chk_head("rel_000", 12'h000);
        chk("rel_c2_addr", {20'h0, address_imem}, 32'h2);
        @(negedge clk); chk_head("rel_001", 12'h001);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the width of the imem word address and all PC signals.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of the instruction word.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset: 0 clears all state immediately, 1 runs.
REQ-005 address_imem  output  ADDR_W  SHALL be the word address to imem, driven directly from the fetch PC register.
REQ-006 q_imem  input  DATA_W  SHALL be the imem read data, valid in the cycle after the address was sampled.
REQ-007 redirect_valid  input  1  SHALL request a PC change (branch/jump) from the processor.
REQ-008 redirect_pc  input  ADDR_W  SHALL be the new fetch address, qualified by redirect_valid.
REQ-009 dec_ready  input  1  SHALL indicate decode accepts the presented instruction this cycle.
REQ-010 if_valid  output  1  SHALL indicate if_instr/if_pc/if_pc_plus1 hold a valid fetched instruction.
REQ-011 if_instr  output  DATA_W  SHALL be the instruction at the FIFO head.
REQ-012 if_pc  output  ADDR_W  SHALL be the word address of if_instr.
REQ-013 if_pc_plus1  output  ADDR_W  SHALL be if_pc+1 modulo 2^ADDR_W.

Function
REQ-014 The block SHALL model imem as synchronous: the address sampled at edge k returns data during cycle k+1.
REQ-015 The block SHALL hold a 2-entry FIFO of {instr, pc}; the head drives the if_* outputs.
REQ-016 pop SHALL equal if_valid AND dec_ready AND NOT redirect_valid; a popped entry leaves at that edge.
REQ-017 issue SHALL be asserted when (count + inflight - pop) < 2 and redirect_valid = 0.
REQ-018 On issue, the fetch PC SHALL increment by 1 at the edge, wrapping 2^ADDR_W-1 -> 0; otherwise it SHALL hold.
REQ-019 The inflight flag SHALL be set at the edge to the value of issue, recording the PC that was issued.
REQ-020 When inflight = 1, the FIFO SHALL write {q_imem, recorded PC} at the edge; when inflight = 0, q_imem SHALL be ignored.
REQ-021 Pop and write in the same cycle SHALL leave count unchanged; the FIFO SHALL never overflow or underflow.
REQ-022 On redirect_valid = 1 at an edge: fetch PC <- redirect_pc, FIFO count <- 0, inflight <- 0; any response arriving next cycle SHALL be discarded.
REQ-023 redirect SHALL take priority over pop, write and issue in the same cycle.
REQ-024 After a redirect edge, if_valid SHALL be 0 for the next cycle; the redirect_pc instruction SHALL appear 2 edges after the redirect edge.
REQ-025 With dec_ready held at 1, steady-state throughput SHALL be one instruction per cycle with no bubbles.
REQ-026 With dec_ready = 0, outputs SHALL hold stable and issue SHALL stop once count + inflight reaches 2.

Reset
REQ-027 While reset = 0: fetch PC = 0, address_imem = 0, inflight = 0, FIFO empty, if_valid = 0, and if_instr, if_pc and if_pc_plus1 = 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions at once.
REQ-029 After reset release, address 0 SHALL be issued at the first edge, and if_valid SHALL rise after the second edge.

Verification
REQ-030 The bench imem model SHALL return q_imem = 32'hA000_0000 | address, registered one cycle.
REQ-031 Case: reset release, dec_ready = 1 -> if_pc sequence 0,1,2,3... one per cycle; if_instr = A000_0000|pc; if_pc_plus1 = pc+1.
REQ-032 Case: dec_ready = 0 for 5 cycles at pc 4 -> if_pc holds 4 and address_imem stalls at 6; on release, 4,5,6,7 follow with no loss or duplicate.
REQ-033 Case: redirect_valid pulse with redirect_pc = 12'h100 while the FIFO is full -> next cycle if_valid = 0; then 0x100, 0x101... with no stale instruction delivered.
REQ-034 Case: start at redirect_pc = 12'hFFE -> sequence FFE, FFF, 000, 001; if_pc_plus1 at FFF = 000.
REQ-035 Case: redirect and dec_ready = 1 in the same cycle as a response arrives -> no pop counted and the response dropped; first delivered pc = redirect_pc.
REQ-036 Case: reset asserted asynchronously mid-stream between edges -> if_valid = 0 and address_imem = 0 immediately; after release the sequence restarts at 0.
